fft_frame_sched: RTL

Frame scheduler for the 512-deep, 40-bit input buffer FIFO (`FIFO_512`) in front of the FFT core. It moves samples through the FIFO in whole frames: it fills the FIFO with one frame of FRAME_LEN samples, then drains that frame to the FFT core over a valid/ready handshake and marks the last sample. It owns the FIFO's wr_en, rd_en and rst, and it flags overflow and underflow errors.

---
 rtl/fft_pkg.sv | 15 +
 rtl/skid_buf2.sv | 64 ++++++
 rtl/fft_frame_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input-buffer frame scheduler.
package fft_pkg;

    localparam int FFT_DATA_W    = 40;
    localparam int FFT_FRAME_LEN = 512;
    localparam int FFT_DEPTH     = 512;
    localparam int FFT_CNT_W     = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry valid/ready output buffer; exposes its occupancy so the producer
// can throttle reads that land one cycle after they are issued.
module skid_buf2 #(
    parameter int W = 41
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    logic [W-1:0] ent0_r;
    logic [W-1:0] ent1_r;
    logic [1:0]   cnt_r;
    logic         pop_s;

    assign out_valid = (cnt_r != 2'd0);
    assign out_data  = ent0_r;
    assign occupancy = cnt_r;
    assign pop_s     = out_valid & out_ready;

    // Entry storage and occupancy; ent0_r is always the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_r <= {W{1'b0}};
            ent1_r <= {W{1'b0}};
            cnt_r  <= 2'd0;
        end else if (clr) begin
            cnt_r <= 2'd0;
        end else begin
            case ({in_valid, pop_s})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        ent0_r <= in_data;
                    end else begin
                        ent1_r <= in_data;
                    end
                    cnt_r <= cnt_r + 2'd1;
                end
                2'b01: begin
                    ent0_r <= ent1_r;
                    cnt_r  <= cnt_r - 2'd1;
                end
                2'b11: begin
                    if (cnt_r == 2'd2) begin
                        ent0_r <= ent1_r;
                        ent1_r <= in_data;
                    end else begin
                        ent0_r <= in_data;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/fft_frame_sched.sv
// Frame scheduler: fills the external FIFO with one frame, then drains it to the
// FFT core through a 2-entry skid buffer, tagging the final beat of the frame.
module fft_frame_sched
    import fft_pkg::*;
#(
    parameter int DATA_W    = FFT_DATA_W,
    parameter int FRAME_LEN = FFT_FRAME_LEN,
    parameter int DEPTH     = FFT_DEPTH,
    parameter int CNT_W     = FFT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic [DATA_W-1:0] fifo_din,
    output logic              fifo_wr_en,
    output logic              fifo_rd_en,
    output logic              fifo_rst,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    output logic              busy,
    output logic              ovf_err,
    output logic              unf_err
);

    // A frame can never be larger than what the FIFO holds.
    localparam int FRAME_CAP = (FRAME_LEN < DEPTH) ? FRAME_LEN : DEPTH;
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_CAP);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_CAP - 1);

    sched_state_e     state_r;
    logic             busy_r;
    logic [CNT_W-1:0] wr_cnt_r;
    logic [CNT_W-1:0] rd_cnt_r;
    logic [CNT_W-1:0] rd_issued_r;
    logic             inflight_r;
    logic             inflight_last_r;
    logic             abort_q_r;
    logic             ovf_err_r;
    logic             unf_err_r;

    logic             s_ready_s;
    logic             wr_en_s;
    logic             rd_en_s;
    logic             pop_s;
    logic [2:0]       load_s;
    logic [1:0]       occ_s;
    logic             skid_valid_s;
    logic             skid_last_s;
    logic [DATA_W-1:0] skid_data_s;

    assign fifo_din   = s_data;
    assign fifo_wr_en = wr_en_s;
    assign fifo_rd_en = rd_en_s;
    assign fifo_rst   = rst | abort_q_r;
    assign s_ready    = s_ready_s;
    assign m_valid    = skid_valid_s;
    assign m_data     = skid_data_s;
    assign m_last     = skid_valid_s & skid_last_s;
    assign busy       = busy_r;
    assign ovf_err    = ovf_err_r;
    assign unf_err    = unf_err_r;
    assign pop_s      = skid_valid_s & m_ready;

    // Write acceptance in FILL and read issue in DRAIN; abort suppresses both.
    always_comb begin
        s_ready_s = 1'b0;
        wr_en_s   = 1'b0;
        rd_en_s   = 1'b0;
        load_s    = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        if (abort) begin
            rd_en_s = 1'b0;
        end else if (state_r == ST_FILL) begin
            s_ready_s = !fifo_full;
            wr_en_s   = s_valid & !fifo_full;
        end else if (state_r == ST_DRAIN) begin
            rd_en_s = (load_s < 3'd2) && (rd_issued_r < FRAME_CNT);
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Frame FSM with its counters and the read-in-flight tracking.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state_r         <= ST_IDLE;
            busy_r          <= 1'b0;
            wr_cnt_r        <= {CNT_W{1'b0}};
            rd_cnt_r        <= {CNT_W{1'b0}};
            rd_issued_r     <= {CNT_W{1'b0}};
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            inflight_r      <= rd_en_s;
            inflight_last_r <= rd_en_s && (rd_issued_r == LAST_IDX);
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        state_r <= ST_FILL;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (wr_en_s) begin
                        if (wr_cnt_r == LAST_IDX) begin
                            wr_cnt_r <= {CNT_W{1'b0}};
                            state_r  <= ST_DRAIN;
                        end else begin
                            wr_cnt_r <= wr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_DRAIN: begin
                    if (rd_en_s) begin
                        rd_issued_r <= rd_issued_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    if (pop_s) begin
                        if (rd_cnt_r == LAST_IDX) begin
                            rd_cnt_r    <= {CNT_W{1'b0}};
                            rd_issued_r <= {CNT_W{1'b0}};
                            state_r     <= enable ? ST_FILL : ST_IDLE;
                            busy_r      <= enable;
                        end else begin
                            rd_cnt_r <= rd_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags and the delayed abort that resets the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            abort_q_r <= 1'b0;
            ovf_err_r <= 1'b0;
            unf_err_r <= 1'b0;
        end else begin
            abort_q_r <= abort;
            if ((state_r == ST_FILL) && s_valid && fifo_full && (wr_cnt_r < FRAME_CNT)) begin
                ovf_err_r <= 1'b1;
            end else begin
                ovf_err_r <= ovf_err_r;
            end
            if (rd_en_s && fifo_empty) begin
                unf_err_r <= 1'b1;
            end else begin
                unf_err_r <= unf_err_r;
            end
        end
    end

    skid_buf2 #(
        .W(DATA_W + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clr       (abort),
        .in_valid  (inflight_r),
        .in_data   ({inflight_last_r, fifo_dout}),
        .out_ready (m_ready),
        .out_valid (skid_valid_s),
        .out_data  ({skid_last_s, skid_data_s}),
        .occupancy (occ_s)
    );

endmodule
